// File: rtl/thread_seq.sv
// thread_seq: instruction thread for the systolic-array controller.
// Fetches 32-bit words from imem, then executes TERMINATE / WRITE / LOAD / COMP /
// LOOP. Opcodes 5-7 trap into a sticky error halt that only reset clears.
//
// Optional feature macro: THREAD_SEQ_WRITE_CHECKSUM_EN. When it is defined, WRITE
// appends an XOR checksum byte after the data bytes and adds one to the byte count.
//
// Ports:
//   clock, reset_n           system clock, asynchronous active-low reset
//   running                  run enable, sampled at each instruction boundary
//   idle / err               high in DONE or ERR / sticky illegal-opcode flag
//   imem_addr / imem_data    byte PC out, instruction word back one cycle later
//   bmem_addr / bmem_data    word address out, data word back one cycle later
//   write_*                  UART lock handshake plus valid/ready byte stream
//   B_addr, load_*           LOAD base address and lock/finish handshake
//   A/D/C_addr, comp_*       COMP base addresses and lock/finish handshake
// Every output comes straight from a flop.
module thread_seq #(
  parameter int BITWIDTH    = 32,
  parameter int ADDR_W      = 8,
  parameter int ADDR_SHIFT  = 8,
  parameter int BLOCK_WORDS = 16,
  parameter int WORD_BYTES  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                running,
  output logic                idle,
  output logic                err,
  output logic [BITWIDTH-1:0] imem_addr,
  input  logic [BITWIDTH-1:0] imem_data,
  output logic [BITWIDTH-1:0] bmem_addr,
  input  logic [BITWIDTH-1:0] bmem_data,
  output logic                write_lock_req,
  input  logic                write_lock_res,
  input  logic                write_ready,
  output logic [7:0]          write_data,
  output logic                write_data_valid,
  output logic [BITWIDTH-1:0] B_addr,
  output logic                load_lock_req,
  input  logic                load_lock_res,
  input  logic                load_finished,
  output logic [BITWIDTH-1:0] A_addr,
  output logic [BITWIDTH-1:0] D_addr,
  output logic [BITWIDTH-1:0] C_addr,
  output logic                comp_lock_req,
  input  logic                comp_lock_res,
  input  logic                comp_finished
);

`ifdef THREAD_SEQ_WRITE_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif
  // Frame byte count sent ahead of the header, truncated to 32 bits.
  localparam logic [31:0] BYTE_CNT = 32'(1 + WORD_BYTES * BLOCK_WORDS) + (CSUM_EN ? 32'd1 : 32'd0);

  typedef enum logic [3:0] {
    S_DONE, S_FETCH, S_DECODE, S_W_ACQ, S_W_CNT, S_W_HDR, S_W_RD, S_W_BYTE,
    S_W_REL, S_L_ACQ, S_L_WAIT, S_L_REL, S_C_ACQ, S_C_WAIT, S_C_REL, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [BITWIDTH-1:0] pc_q, pc_d, word_q, word_d, bmem_addr_q, bmem_addr_d;
  logic [BITWIDTH-1:0] b_addr_q, b_addr_d, a_addr_q, a_addr_d;
  logic [BITWIDTH-1:0] d_addr_q, d_addr_d, c_addr_q, c_addr_d;
  logic [ADDR_W-1:0]   loop_ctr_q, loop_ctr_d;
  logic [31:0]         byte_idx_q, byte_idx_d, word_idx_q, word_idx_d;
  logic [7:0]          hdr_q, hdr_d, chk_q, chk_d, write_data_q, write_data_d;
  logic loop_active_q, loop_active_d, err_q, err_d, idle_q, idle_d;
  logic rd_phase_q, rd_phase_d, csum_q, csum_d;
  logic write_lock_req_q, write_lock_req_d, write_data_valid_q, write_data_valid_d;
  logic load_lock_req_q, load_lock_req_d, comp_lock_req_q, comp_lock_req_d;

  // Instruction fields and derived values.
  logic [2:0]          op_s;
  logic [ADDR_W-1:0]   f0_s, f1_s, f2_s;
  logic [BITWIDTH-1:0] pc_plus4_s, loop_tgt_s;
  logic [31:0]         byte_idx_nxt_s;
  logic                byte_acc_s;
  assign op_s           = imem_data[2:0];
  assign f0_s           = imem_data[3 +: ADDR_W];
  assign f1_s           = imem_data[3 + ADDR_W +: ADDR_W];
  assign f2_s           = imem_data[3 + 2*ADDR_W +: ADDR_W];
  assign pc_plus4_s     = pc_q + BITWIDTH'(4);
  assign loop_tgt_s     = BITWIDTH'(f0_s) << 2;
  assign byte_idx_nxt_s = byte_idx_q + 32'd1;
  assign byte_acc_s     = write_data_valid_q && write_ready;

  // Next-state and next-output logic for the thread FSM.
  always_comb begin
    state_d = state_q;  pc_d = pc_q;  word_d = word_q;  bmem_addr_d = bmem_addr_q;
    b_addr_d = b_addr_q;  a_addr_d = a_addr_q;  d_addr_d = d_addr_q;  c_addr_d = c_addr_q;
    loop_ctr_d = loop_ctr_q;  loop_active_d = loop_active_q;  err_d = err_q;
    byte_idx_d = byte_idx_q;  word_idx_d = word_idx_q;  hdr_d = hdr_q;  chk_d = chk_q;
    rd_phase_d = rd_phase_q;  csum_d = csum_q;  write_data_d = write_data_q;
    write_lock_req_d = write_lock_req_q;  write_data_valid_d = write_data_valid_q;
    load_lock_req_d = load_lock_req_q;  comp_lock_req_d = comp_lock_req_q;
    case (state_q)
      S_DONE: begin
        if (running) begin
          pc_d = '0;  loop_active_d = 1'b0;  state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!running) begin
          state_d = S_DONE;
        end else begin
          case (op_s)
            3'd0: state_d = S_DONE;
            3'd1: begin
              bmem_addr_d = BITWIDTH'(f0_s) << ADDR_SHIFT;
              hdr_d = f1_s[7:0];  word_idx_d = 32'd0;  csum_d = 1'b0;
              write_lock_req_d = 1'b1;  state_d = S_W_ACQ;
            end
            3'd2: begin
              b_addr_d = BITWIDTH'(f0_s) << ADDR_SHIFT;
              load_lock_req_d = 1'b1;  state_d = S_L_ACQ;
            end
            3'd3: begin
              a_addr_d = BITWIDTH'(f0_s) << ADDR_SHIFT;
              d_addr_d = BITWIDTH'(f1_s) << ADDR_SHIFT;
              c_addr_d = BITWIDTH'(f2_s) << ADDR_SHIFT;
              comp_lock_req_d = 1'b1;  state_d = S_C_ACQ;
            end
            3'd4: begin
              // Single counter: first visit arms it, later visits count it down.
              if (!loop_active_q) begin
                if (f1_s == '0) begin
                  pc_d = pc_plus4_s;
                end else begin
                  loop_ctr_d = f1_s - ADDR_W'(1);  loop_active_d = 1'b1;  pc_d = loop_tgt_s;
                end
              end else begin
                if (loop_ctr_q != '0) begin
                  loop_ctr_d = loop_ctr_q - ADDR_W'(1);  pc_d = loop_tgt_s;
                end else begin
                  loop_active_d = 1'b0;  pc_d = pc_plus4_s;
                end
              end
              state_d = S_FETCH;
            end
            default: begin
              err_d = 1'b1;  state_d = S_ERR;
            end
          endcase
        end
      end
      S_W_ACQ: begin
        if (write_lock_res) begin
          write_data_d = BYTE_CNT[7:0];  write_data_valid_d = 1'b1;
          byte_idx_d = 32'd0;  state_d = S_W_CNT;
        end else begin
          state_d = S_W_ACQ;
        end
      end
      S_W_CNT: begin
        if (byte_acc_s) begin
          if (byte_idx_q == 32'd3) begin
            write_data_d = hdr_q;  chk_d = hdr_q;  state_d = S_W_HDR;
          end else begin
            byte_idx_d = byte_idx_nxt_s;
            write_data_d = 8'(BYTE_CNT >> {byte_idx_nxt_s[28:0], 3'b000});
          end
        end else begin
          state_d = S_W_CNT;
        end
      end
      S_W_HDR: begin
        if (byte_acc_s) begin
          write_data_valid_d = 1'b0;  rd_phase_d = 1'b0;  state_d = S_W_RD;
        end else begin
          state_d = S_W_HDR;
        end
      end
      S_W_RD: begin
        // Phase 0 presents the address; bmem_data is valid in phase 1.
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          word_d = bmem_data;  write_data_d = bmem_data[7:0];
          write_data_valid_d = 1'b1;  byte_idx_d = 32'd0;  state_d = S_W_BYTE;
        end
      end
      S_W_BYTE: begin
        if (!byte_acc_s) begin
          state_d = S_W_BYTE;
        end else if (csum_q) begin
          write_data_valid_d = 1'b0;  write_lock_req_d = 1'b0;  csum_d = 1'b0;  state_d = S_W_REL;
        end else begin
          chk_d = chk_q ^ write_data_q;
          if (byte_idx_q != 32'(WORD_BYTES - 1)) begin
            byte_idx_d = byte_idx_nxt_s;
            write_data_d = 8'(word_q >> {byte_idx_nxt_s[28:0], 3'b000});
          end else if (word_idx_q != 32'(BLOCK_WORDS - 1)) begin
            write_data_valid_d = 1'b0;  word_idx_d = word_idx_q + 32'd1;
            bmem_addr_d = bmem_addr_q + BITWIDTH'(1);  rd_phase_d = 1'b0;  state_d = S_W_RD;
          end else if (CSUM_EN) begin
            write_data_d = chk_q ^ write_data_q;  csum_d = 1'b1;
          end else begin
            write_data_valid_d = 1'b0;  write_lock_req_d = 1'b0;  state_d = S_W_REL;
          end
        end
      end
      S_W_REL: begin
        if (!write_lock_res) begin
          pc_d = pc_plus4_s;  state_d = S_FETCH;
        end else begin
          state_d = S_W_REL;
        end
      end
      S_L_ACQ: state_d = load_lock_res ? S_L_WAIT : S_L_ACQ;
      S_L_WAIT: begin
        if (load_finished) begin
          load_lock_req_d = 1'b0;  state_d = S_L_REL;
        end else begin
          state_d = S_L_WAIT;
        end
      end
      S_L_REL: begin
        if (!load_lock_res) begin
          pc_d = pc_plus4_s;  state_d = S_FETCH;
        end else begin
          state_d = S_L_REL;
        end
      end
      S_C_ACQ: state_d = comp_lock_res ? S_C_WAIT : S_C_ACQ;
      S_C_WAIT: begin
        if (comp_finished) begin
          comp_lock_req_d = 1'b0;  state_d = S_C_REL;
        end else begin
          state_d = S_C_WAIT;
        end
      end
      S_C_REL: begin
        if (!comp_lock_res) begin
          pc_d = pc_plus4_s;  state_d = S_FETCH;
        end else begin
          state_d = S_C_REL;
        end
      end
      S_ERR: state_d = S_ERR;
      default: begin
        err_d = 1'b1;  state_d = S_ERR;
      end
    endcase
    idle_d = (state_d == S_DONE) || (state_d == S_ERR);
  end

  // State and output registers; reset drops every request asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DONE;  pc_q <= '0;  word_q <= '0;  bmem_addr_q <= '0;
      b_addr_q <= '0;  a_addr_q <= '0;  d_addr_q <= '0;  c_addr_q <= '0;
      loop_ctr_q <= '0;  loop_active_q <= 1'b0;  err_q <= 1'b0;  idle_q <= 1'b1;
      byte_idx_q <= 32'd0;  word_idx_q <= 32'd0;  hdr_q <= 8'd0;  chk_q <= 8'd0;
      rd_phase_q <= 1'b0;  csum_q <= 1'b0;  write_data_q <= 8'd0;
      write_lock_req_q <= 1'b0;  write_data_valid_q <= 1'b0;
      load_lock_req_q <= 1'b0;  comp_lock_req_q <= 1'b0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  word_q <= word_d;  bmem_addr_q <= bmem_addr_d;
      b_addr_q <= b_addr_d;  a_addr_q <= a_addr_d;  d_addr_q <= d_addr_d;  c_addr_q <= c_addr_d;
      loop_ctr_q <= loop_ctr_d;  loop_active_q <= loop_active_d;  err_q <= err_d;  idle_q <= idle_d;
      byte_idx_q <= byte_idx_d;  word_idx_q <= word_idx_d;  hdr_q <= hdr_d;  chk_q <= chk_d;
      rd_phase_q <= rd_phase_d;  csum_q <= csum_d;  write_data_q <= write_data_d;
      write_lock_req_q <= write_lock_req_d;  write_data_valid_q <= write_data_valid_d;
      load_lock_req_q <= load_lock_req_d;  comp_lock_req_q <= comp_lock_req_d;
    end
  end

  assign idle = idle_q;                      assign err = err_q;
  assign imem_addr = pc_q;                   assign bmem_addr = bmem_addr_q;
  assign write_lock_req = write_lock_req_q;  assign write_data = write_data_q;
  assign write_data_valid = write_data_valid_q;
  assign B_addr = b_addr_q;                  assign load_lock_req = load_lock_req_q;
  assign A_addr = a_addr_q;  assign D_addr = d_addr_q;  assign C_addr = c_addr_q;
  assign comp_lock_req = comp_lock_req_q;

endmodule

// File: tb/tb_thread_seq.sv
module tb_thread_seq;
  logic clock = 1'b0, reset_n = 1'b0, running = 1'b0;
  logic idle, err, write_lock_req, write_data_valid, load_lock_req, comp_lock_req;
  logic [31:0] imem_addr, imem_data, bmem_addr, bmem_data, B_addr, A_addr, D_addr, C_addr;
  logic [7:0] write_data;
  logic write_lock_res = 1'b0, write_ready = 1'b1;
  logic load_lock_res = 1'b0, load_finished = 1'b0, comp_lock_res = 1'b0, comp_finished = 1'b0;
  logic ready_toggle = 1'b0;

  thread_seq #(.BITWIDTH(32), .ADDR_W(8), .ADDR_SHIFT(8), .BLOCK_WORDS(4), .WORD_BYTES(4)) dut (
    .clock(clock), .reset_n(reset_n), .running(running), .idle(idle), .err(err),
    .imem_addr(imem_addr), .imem_data(imem_data), .bmem_addr(bmem_addr), .bmem_data(bmem_data),
    .write_lock_req(write_lock_req), .write_lock_res(write_lock_res), .write_ready(write_ready),
    .write_data(write_data), .write_data_valid(write_data_valid), .B_addr(B_addr),
    .load_lock_req(load_lock_req), .load_lock_res(load_lock_res), .load_finished(load_finished),
    .A_addr(A_addr), .D_addr(D_addr), .C_addr(C_addr), .comp_lock_req(comp_lock_req),
    .comp_lock_res(comp_lock_res), .comp_finished(comp_finished));

  always #5 clock = ~clock;

  logic [31:0] imem [0:15];
  logic [31:0] bmem [0:511];
  int n_checks = 0, n_fail = 0;

  // Synchronous memories: data arrives one cycle after the address.
  always @(posedge clock) begin
    imem_data <= imem[imem_addr[5:2]];
    bmem_data <= bmem[bmem_addr[8:0]];
  end

  // Peripheral models: UART lock follows req, LOAD/COMP grant after 3 cycles, finish pulse later.
  int ld_cnt = 0, cp_cnt = 0;
  always @(posedge clock) begin
    write_lock_res <= write_lock_req;
    write_ready <= ready_toggle ? ~write_ready : 1'b1;
    if (!load_lock_req) begin
      ld_cnt <= 0; load_lock_res <= 1'b0; load_finished <= 1'b0;
    end else begin
      ld_cnt <= ld_cnt + 1; load_lock_res <= (ld_cnt >= 2); load_finished <= (ld_cnt == 5);
    end
    if (!comp_lock_req) begin
      cp_cnt <= 0; comp_lock_res <= 1'b0; comp_finished <= 1'b0;
    end else begin
      cp_cnt <= cp_cnt + 1; comp_lock_res <= (cp_cnt >= 2); comp_finished <= (cp_cnt == 5);
    end
  end

  // Monitor: byte capture, hold-stability, pulse counts and req-drop timing.
  logic [7:0] got [$];
  int cyc = 0, last_acc = 0, req_fall = 0, stab_bad = 0, drop_bad = 0, ld_pulses = 0, cp_pulses = 0;
  logic p_wait = 1'b0, p_wreq = 1'b0, p_ld = 1'b0, p_cp = 1'b0, p_ldfin = 1'b0, p_cpfin = 1'b0;
  logic [7:0] p_data = 8'd0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      p_wait <= 1'b0; p_wreq <= 1'b0; p_ld <= 1'b0; p_cp <= 1'b0; p_ldfin <= 1'b0; p_cpfin <= 1'b0;
    end else begin
      if (write_data_valid && write_ready) begin
        got.push_back(write_data); last_acc <= cyc;
      end
      if (p_wreq && !write_lock_req) req_fall <= cyc;
      if (p_wait && !(write_data_valid && write_data == p_data)) stab_bad <= stab_bad + 1;
      if (load_lock_req && !p_ld) ld_pulses <= ld_pulses + 1;
      if (comp_lock_req && !p_cp) cp_pulses <= cp_pulses + 1;
      if ((p_ldfin && load_lock_req) || (p_cpfin && comp_lock_req)) drop_bad <= drop_bad + 1;
      p_wait <= write_data_valid && !write_ready; p_data <= write_data;
      p_wreq <= write_lock_req; p_ld <= load_lock_req; p_cp <= comp_lock_req;
      p_ldfin <= load_finished && load_lock_req; p_cpfin <= comp_finished && comp_lock_req;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int f0, input int f1, input int f2);
    logic [2:0] o; logic [7:0] a, b, c;
    o = 3'(op); a = 8'(f0); b = 8'(f1); c = 8'(f2);
    return {5'd0, c, b, a, o};
  endfunction

  // Start the program, wait for it to leave and return to idle, then stop running.
  task automatic run_prog(input string tag);
    bit busy = 1'b0, done = 1'b0;
    running = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clock); #1;
      if (!idle) busy = 1'b1;
      else if (busy) done = 1'b1;
    end
    running = 1'b0;
    check({tag, "_completed"}, {31'd0, done}, 32'd1);
  endtask

  logic [7:0] exp_b [0:21];
  int exp_n, base, ld0, cp0, st0;

  task automatic check_frame(input string tag);
    check({tag, "_nbytes"}, 32'(got.size() - base), 32'(exp_n));
    for (int i = 0; i < exp_n; i++)
      check({tag, "_byte"}, (base + i < got.size()) ? {24'd0, got[base + i]} : 32'hDEAD, {24'd0, exp_b[i]});
    check({tag, "_req_fall"}, 32'(req_fall), 32'(last_acc + 1));
    check({tag, "_stable"}, 32'(stab_bad), 32'd0);
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    check({tag, "_wreq"}, {31'd0, write_lock_req}, 32'd0);
    check({tag, "_pc"}, imem_addr, 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'd0;
    for (int i = 0; i < 512; i++) bmem[i] = 32'd0;
    for (int i = 0; i < 4; i++) bmem[256 + i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
`ifdef THREAD_SEQ_WRITE_CHECKSUM_EN
    exp_n = 22; exp_b[0] = 8'h12;
`else
    exp_n = 21; exp_b[0] = 8'h11;
`endif
    exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00; exp_b[4] = 8'hA5;
    for (int i = 0; i < 16; i++) exp_b[5 + i] = 8'(i);
    exp_b[21] = 8'hA5;  // A5 ^ (0^1^...^15) = A5

    // Reset state
    #12;
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_reqs", {29'd0, write_lock_req, load_lock_req, comp_lock_req}, 32'd0);
    check("rst_valid", {31'd0, write_data_valid}, 32'd0);
    check("rst_wdata", {24'd0, write_data}, 32'd0);
    check("rst_addrs", imem_addr | bmem_addr | B_addr | A_addr | D_addr | C_addr, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // WRITE with ready always high
    imem[0] = enc(1, 1, 8'hA5, 0); imem[1] = enc(0, 0, 0, 0);
    base = got.size(); st0 = stab_bad;
    run_prog("w1"); check_frame("w1");

    // WRITE with ready toggling
    ready_toggle = 1'b1; base = got.size();
    run_prog("w2"); check_frame("w2");
    ready_toggle = 1'b0;

    // LOAD then COMP, grants delayed
    imem[0] = enc(2, 2, 0, 0); imem[1] = enc(3, 1, 3, 4); imem[2] = enc(0, 0, 0, 0);
    ld0 = ld_pulses; cp0 = cp_pulses;
    run_prog("lc");
    check("lc_B", B_addr, 32'h200);
    check("lc_A", A_addr, 32'h100);
    check("lc_D", D_addr, 32'h300);
    check("lc_C", C_addr, 32'h400);
    check("lc_pc", imem_addr, 32'd8);
    check("lc_ld_pulses", 32'(ld_pulses - ld0), 32'd1);
    check("lc_cp_pulses", 32'(cp_pulses - cp0), 32'd1);
    check("lc_req_drop", 32'(drop_bad), 32'd0);

    // LOOP: body LOAD runs count+1 = 3 times
    imem[0] = enc(2, 1, 0, 0); imem[1] = enc(4, 0, 2, 0); imem[2] = enc(0, 0, 0, 0);
    ld0 = ld_pulses;
    run_prog("loop");
    check("loop_ld_pulses", 32'(ld_pulses - ld0), 32'd3);
    check("loop_pc", imem_addr, 32'd8);
    check("loop_B", B_addr, 32'h100);

    // Async reset in the middle of the data bytes
    imem[0] = enc(1, 1, 8'hA5, 0); imem[1] = enc(0, 0, 0, 0);
    base = got.size(); running = 1'b1;
    for (int i = 0; i < 200 && (got.size() - base) < 7; i++) begin @(posedge clock); #1; end
    check("ar_in_frame", {30'd0, write_lock_req, write_data_valid}, 32'd3);
    @(negedge clock); #2; reset_n = 1'b0; #1;
    check("ar_wreq", {31'd0, write_lock_req}, 32'd0);
    check("ar_valid", {31'd0, write_data_valid}, 32'd0);
    running = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("ar_idle", {31'd0, idle}, 32'd1);

    // Illegal opcode traps; ERR survives running toggles until reset
    imem[0] = enc(6, 0, 0, 0);
    run_prog("ill");
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_reqs", {29'd0, write_lock_req, load_lock_req, comp_lock_req}, 32'd0);
    check("ill_pc", imem_addr, 32'd0);
    for (int i = 0; i < 6; i++) begin running = ~running; @(posedge clock); #1; end
    check("ill_stay_err", {31'd0, err}, 32'd1);
    check("ill_stay_idle", {31'd0, idle}, 32'd1);
    check("ill_stay_reqs", {29'd0, write_lock_req, load_lock_req, comp_lock_req}, 32'd0);
    running = 1'b0;
    @(negedge clock); reset_n = 1'b0; #1;
    check("ill_rst_err", {31'd0, err}, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
